// File: rtl/ram_cache_dm_refill.sv
// ram_cache_dm_refill: direct-mapped write-through data cache with multi-beat refill
// Ports: clk, rst (sync, active-high)
//        CPU:    req, WE, dataType, A, WD -> ready, RD, rd_valid
//        Memory: mem_req, mem_we, mem_addr, mem_wd, mem_be <- mem_rd, mem_ack
// Define CACHE_STATS_EN to add saturating hit_count/miss_count load counters.
module ram_cache_dm_refill #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int INDEX_WIDTH  = 4,
    parameter int OFFSET_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  WE,
    input  logic [1:0]            dataType,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] WD,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] RD,
    output logic                  rd_valid,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic [3:0]            mem_be,
    input  logic [DATA_WIDTH-1:0] mem_rd,
    input  logic                  mem_ack
`ifdef CACHE_STATS_EN
   ,output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH - 2;
    localparam int WA = ADDR_WIDTH - 2;
    localparam int LW = INDEX_WIDTH + OFFSET_WIDTH;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;
    state_t state, state_n;

    logic [2**INDEX_WIDTH-1:0] valid;
    logic [TAG_WIDTH-1:0]      tags  [2**INDEX_WIDTH];
    logic [DATA_WIDTH-1:0]     lines [2**LW];
    logic [WA-1:0]             wa_q;
    logic [3:0]                be_q, be;
    logic [DATA_WIDTH-1:0]     wd_q, wd_rep, merged;
    logic [OFFSET_WIDTH-1:0]   beat, q_off;
    logic [TAG_WIDTH-1:0]      a_tag;
    logic [INDEX_WIDTH-1:0]    a_idx, q_idx;
    logic [LW-1:0]             a_word;
    logic                      hit, accept, last, fill;

    assign a_tag  = A[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign a_idx  = A[OFFSET_WIDTH+2 +: INDEX_WIDTH];
    assign a_word = A[2 +: LW];
    assign hit    = valid[a_idx] && tags[a_idx] == a_tag;
    assign accept = req && state == IDLE;
    assign q_idx  = wa_q[OFFSET_WIDTH +: INDEX_WIDTH];
    assign q_off  = wa_q[OFFSET_WIDTH-1:0];
    assign last   = &beat;
    assign fill   = state == REFILL && mem_ack;

    always_comb begin
        be = dataType == 2'b01 ? 4'b0001 << A[1:0] :
             dataType == 2'b10 ? 4'b0011 << {A[1], 1'b0} : 4'b1111;
        wd_rep = dataType == 2'b01 ? {4{WD[7:0]}} :
                 dataType == 2'b10 ? {2{WD[15:0]}} : WD;
        merged = lines[a_word];
        for (int i = 0; i < 4; i++)
            if (be[i]) merged[8*i +: 8] = wd_rep[8*i +: 8];
        state_n = accept ? (WE ? WRITE : hit ? IDLE : REFILL) :
                  (state == WRITE && mem_ack) || (fill && last) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            valid    <= '0;
            rd_valid <= 1'b0;
            RD       <= '0;
            beat     <= '0;
        end else begin
            state    <= state_n;
            rd_valid <= 1'b0;
            if (accept) begin
                wa_q <= A[ADDR_WIDTH-1:2];
                be_q <= be;
                wd_q <= wd_rep;
                beat <= '0;
                if (!WE && hit) begin
                    RD       <= lines[a_word];
                    rd_valid <= 1'b1;
                end
                // A line under refill must never look valid, even if the refill is aborted.
                if (!WE && !hit) valid[a_idx] <= 1'b0;
            end
            if (fill) begin
                beat <= beat + OFFSET_WIDTH'(1);
                if (last) begin
                    valid[q_idx] <= 1'b1;
                    tags[q_idx]  <= wa_q[WA-1 -: TAG_WIDTH];
                    // The requested word may be arriving on this very beat.
                    RD       <= beat == q_off ? mem_rd : lines[{q_idx, q_off}];
                    rd_valid <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && WE && hit) lines[a_word] <= merged;
        if (fill) lines[{q_idx, beat}] <= mem_rd;
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept && !WE) begin
            if (hit) hit_count <= &hit_count ? hit_count : hit_count + 32'd1;
            else miss_count <= &miss_count ? miss_count : miss_count + 32'd1;
        end
    end
`endif

    assign ready    = state == IDLE;
    assign mem_req  = state != IDLE;
    assign mem_we   = state == WRITE;
    assign mem_addr = state == REFILL ? {wa_q[WA-1:OFFSET_WIDTH], beat, 2'b00} :
                      state == WRITE ? {wa_q, 2'b00} : '0;
    assign mem_wd   = state == WRITE ? wd_q : '0;
    assign mem_be   = state == WRITE ? be_q : 4'b0000;
endmodule

// File: tb/tb_ram_cache_dm_refill.sv
// tb_ram_cache_dm_refill: directed and randomized bench against a transparent-cache model
module tb_ram_cache_dm_refill;
    logic        clk = 1'b0;
    logic        rst, req, WE;
    logic [1:0]  dataType;
    logic [15:0] A;
    logic [31:0] WD;
    logic        ready, rd_valid, mem_req, mem_we, mem_ack;
    logic [31:0] RD, mem_wd, mem_rd;
    logic [15:0] mem_addr;
    logic [3:0]  mem_be;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    ram_cache_dm_refill dut (
        .clk(clk), .rst(rst), .req(req), .WE(WE), .dataType(dataType), .A(A), .WD(WD),
        .ready(ready), .RD(RD), .rd_valid(rd_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_be(mem_be), .mem_rd(mem_rd), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
       ,.hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    typedef struct {logic [31:0] v; int c;} rd_t;
    typedef struct {logic [15:0] a; logic [3:0] be; logic [31:0] wd;} wr_t;

    int          checks = 0, errors = 0, cyc = 0, acc_cyc = 0, rd_idx = 0;
    logic [31:0] mem [16384];
    rd_t         rd_log[$];
    wr_t         wr_log[$];
    logic [15:0] beat_log[$];

    function automatic logic [31:0] mem_init(int w);
        return 32'h1000 + (w & 3) + ((((w >> 2) ^ 'h10) & 'hFFF) << 16);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    // Behavioural model: the cache is transparent (write-through, no other writer), so any
    // load returns the current memory word; only hit/miss timing depends on the tag store.
    bit          chk_en = 0;
    bit          mv [16];
    int          mt [16];
    int          m_op = 0, m_addr = 0, m_beat = 0, m_hits = 0, m_misses = 0;
    logic [3:0]  m_be;
    logic [31:0] m_wd, m_rd;
    bit          m_rv = 0;

    always @(posedge clk) begin
        int idx;
        cyc++;
        if (rst) begin
            foreach (mv[i]) mv[i] = 0;
            m_op = 0; m_rv = 0; m_hits = 0; m_misses = 0;
            chk_en = 1;
        end else begin
            m_rv = 0;
            if (m_op == 0 && req) begin
                m_addr = int'(A);
                idx = (m_addr >> 4) & 15;
                if (WE) begin
                    m_op = 2;
                    m_be = dataType == 1 ? 4'(1 << (m_addr % 4)) :
                           dataType == 2 ? 4'(3 << (m_addr & 2)) : 4'hF;
                    m_wd = dataType == 1 ? (WD & 'hFF) * 32'h01010101 :
                           dataType == 2 ? (WD & 'hFFFF) * 32'h00010001 : WD;
                end else if (mv[idx] && mt[idx] == (m_addr >> 8)) begin
                    m_rv = 1; m_rd = mem[m_addr >> 2]; m_hits++;
                end else begin
                    mv[idx] = 0; m_op = 1; m_beat = 0; m_misses++;
                end
            end else if (m_op == 1 && mem_ack) begin
                m_beat++;
                if (m_beat == 4) begin
                    idx = (m_addr >> 4) & 15;
                    mv[idx] = 1; mt[idx] = m_addr >> 8;
                    m_op = 0; m_rv = 1; m_rd = mem[m_addr >> 2];
                end
            end else if (m_op == 2 && mem_ack) m_op = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", ready, m_op == 0);
            chk("mem_req", mem_req, m_op != 0);
            chk("mem_we", mem_we, m_op == 2);
            chk("mem_addr", mem_addr, m_op == 1 ? ((m_addr >> 4) << 4) + 4 * m_beat :
                                      m_op == 2 ? m_addr & 'hFFFC : 0);
            chk("mem_wd", mem_wd, m_op == 2 ? m_wd : 0);
            chk("mem_be", mem_be, m_op == 2 ? m_be : 0);
            chk("rd_valid", rd_valid, m_rv);
            if (m_rv) chk("RD", RD, m_rd);
`ifdef CACHE_STATS_EN
            chk("hit_count", hit_count, m_hits);
            chk("miss_count", miss_count, m_misses);
`endif
            if (rd_valid) rd_log.push_back('{RD, cyc});
        end
    end

    // Memory responder: ack after ack_mode idle cycles (-1 = random 0..3); optional stray acks.
    int ack_mode = 0, wait_cnt = 0;
    bit stray = 0;
    initial for (int w = 0; w < 16384; w++) mem[w] = mem_init(w);

    always @(negedge clk) begin
        int w;
        mem_ack = 0;
        mem_rd = $urandom;
        if (mem_req && !rst) begin
            if (wait_cnt == 0) begin
                mem_ack = 1;
                w = int'(mem_addr[15:2]);
                mem_rd = mem[w];
                if (mem_we) begin
                    for (int b = 0; b < 4; b++) if (mem_be[b]) mem[w][8*b +: 8] = mem_wd[8*b +: 8];
                    wr_log.push_back('{mem_addr, mem_be, mem_wd});
                end else beat_log.push_back(mem_addr);
                wait_cnt = ack_mode < 0 ? $urandom_range(0, 3) : ack_mode;
            end else wait_cnt--;
        end else begin
            wait_cnt = ack_mode < 0 ? $urandom_range(0, 3) : ack_mode;
            if (stray && $urandom_range(0, 7) == 0) mem_ack = 1;
        end
    end

    task automatic cpu(input bit we, input bit [1:0] dt, input bit [15:0] a, input bit [31:0] wd);
        int n = 0;
        @(negedge clk);
        req = 1; WE = we; dataType = dt; A = a; WD = wd;
        while (!ready && n < 200) begin @(negedge clk); n++; end
        chk("accept", ready, 1);
        acc_cyc = cyc;
        @(posedge clk);
        #1 req = 0;
    endtask

    task automatic wait_rd(input int acc, output logic [31:0] v, output int lat);
        int n = 0;
        while (rd_log.size() <= rd_idx && n < 100) begin @(posedge clk); n++; end
        chk("rd_arrived", rd_log.size() > rd_idx, 1);
        v = 'x; lat = -1;
        if (rd_log.size() > rd_idx) begin
            v = rd_log[rd_idx].v;
            lat = rd_log[rd_idx].c - acc;
            rd_idx++;
        end
    endtask

    task automatic idle();
        int n = 0;
        @(negedge clk);
        while (!ready && n < 200) begin @(negedge clk); n++; end
        chk("idle", ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        int lat, a0, a1, nb, nw, n;
        rst = 1; req = 0; WE = 0; dataType = 0; A = 0; WD = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        chk("reset_RD", RD, 0);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_mem_req", mem_req, 0);

        nb = beat_log.size();
        cpu(0, 0, 16'h0104, 0); a0 = acc_cyc;
        wait_rd(a0, v, lat);
        chk("t1_rd", v, 32'h00001001);
        chk("t1_latency", lat, 5);
        for (int i = 0; i < 4; i++) chk("t1_beat_addr", beat_log[nb + i], 32'h100 + 4 * i);

        nb = beat_log.size();
        cpu(0, 0, 16'h0108, 0); a0 = acc_cyc;
        cpu(0, 0, 16'h010C, 0); a1 = acc_cyc;
        wait_rd(a0, v, lat);
        chk("t2_rd0", v, 32'h00001002);
        chk("t2_lat0", lat, 1);
        wait_rd(a1, v, lat);
        chk("t2_rd1", v, 32'h00001003);
        chk("t2_lat1", lat, 1);
        chk("t2_back_to_back", a1 - a0, 1);
        chk("t2_no_beats", beat_log.size() - nb, 0);
`ifdef CACHE_STATS_EN
        chk("t2_hit_count", hit_count, 2);
        chk("t2_miss_count", miss_count, 1);
`endif

        nw = wr_log.size();
        cpu(1, 1, 16'h0105, 32'h000000AB);
        idle();
        chk("t3_be", wr_log[nw].be, 4'b0010);
        chk("t3_wd", wr_log[nw].wd, 32'hABABABAB);
        chk("t3_addr", wr_log[nw].a, 16'h0104);
        cpu(0, 0, 16'h0104, 0); a0 = acc_cyc;
        wait_rd(a0, v, lat);
        chk("t3_rd", v, 32'h0000AB01);
        chk("t3_lat", lat, 1);

        nb = beat_log.size();
        cpu(0, 0, 16'h0204, 0); a0 = acc_cyc;
        wait_rd(a0, v, lat);
        chk("t4_rd", v, 32'h00301001);
        chk("t4_lat", lat, 5);
        chk("t4_first_beat", beat_log[nb], 16'h0200);
        cpu(0, 0, 16'h0104, 0); a0 = acc_cyc;
        wait_rd(a0, v, lat);
        chk("t4_reload_rd", v, 32'h0000AB01);
        chk("t4_reload_lat", lat, 5);

        ack_mode = 3;
        nw = wr_log.size();
        cpu(1, 2, 16'h3002, 32'h00001234);
        idle();
        ack_mode = 0;
        chk("t5_be", wr_log[nw].be, 4'b1100);
        chk("t5_wd", wr_log[nw].wd, 32'h12341234);
        chk("t5_addr", wr_log[nw].a, 16'h3000);
        cpu(0, 0, 16'h3000, 0); a0 = acc_cyc;
        wait_rd(a0, v, lat);
        chk("t5_rd", v, 32'h12341000);
        chk("t5_miss_lat", lat, 5);

        nb = beat_log.size();
        cpu(0, 0, 16'h0104, 0);
        n = 0;
        while (beat_log.size() < nb + 2 && n < 100) begin @(posedge clk); n++; end
        @(negedge clk) rst = 1;
        @(negedge clk) rst = 0;
        chk("t6_ready_after_rst", ready, 1);
        nb = beat_log.size();
        cpu(0, 0, 16'h0104, 0); a0 = acc_cyc;
        wait_rd(a0, v, lat);
        chk("t6_rd", v, 32'h0000AB01);
        chk("t6_lat", lat, 5);
        chk("t6_beats", beat_log.size() - nb, 4);
        for (int i = 0; i < 4; i++) chk("t6_beat_addr", beat_log[nb + i], 32'h100 + 4 * i);

        ack_mode = -1;
        stray = 1;
        for (int k = 0; k < 300; k++) begin
            bit [7:0] tg;
            case ($urandom_range(0, 3))
                0: tg = 8'h01;
                1: tg = 8'h02;
                2: tg = 8'h30;
                default: tg = 8'hFF;
            endcase
            cpu($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                {tg, 8'($urandom_range(0, 255))}, $urandom);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        stray = 0;
        idle();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
